// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the 7-segment scan driver: scan FSM states and hex glyphs.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied at the driver.
package seg7_scan_mux_pkg;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   // Maps an active-high segment pattern onto the physical pin polarity.
   function automatic logic [6:0] seg_pol(input logic [6:0] segs, input bit active_low);
      return active_low ? ~segs : segs;
   endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle of the scan driver: data/load/strobe inputs and the pin outputs.
// The master drives digit data and the scan strobe; the slave is the scan driver.
interface seg7_scan_mux_if #(
   parameter int NDIGITS = 4
);

   logic                   tick;
   logic [4*NDIGITS-1:0]   digits;
   logic [NDIGITS-1:0]     dp_in;
   logic                   load;
   logic                   lz_en;
   logic [NDIGITS-1:0]     an;
   logic [6:0]             seg;
   logic                   dp;
   logic                   frame_done;

   modport master (
      output tick, digits, dp_in, load, lz_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  tick, digits, dp_in, load, lz_en,
      output an, seg, dp, frame_done
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph {g,f,e,d,c,b,a}.
// Pure lookup with no state, usable by any display block.
module seg7_hex_decode
   import seg7_scan_mux_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   always_comb begin
      segs = GLYPH_0;
      case (nibble)
         4'h0: segs = GLYPH_0;
         4'h1: segs = GLYPH_1;
         4'h2: segs = GLYPH_2;
         4'h3: segs = GLYPH_3;
         4'h4: segs = GLYPH_4;
         4'h5: segs = GLYPH_5;
         4'h6: segs = GLYPH_6;
         4'h7: segs = GLYPH_7;
         4'h8: segs = GLYPH_8;
         4'h9: segs = GLYPH_9;
         4'hA: segs = GLYPH_A;
         4'hB: segs = GLYPH_B;
         4'hC: segs = GLYPH_C;
         4'hD: segs = GLYPH_D;
         4'hE: segs = GLYPH_E;
         4'hF: segs = GLYPH_F;
         default: segs = GLYPH_0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Tick-paced BLANK/SHOW scan of NDIGITS 7-segment digits with double-buffered data.
// Outputs are registered and move on the same edge as the FSM; no backpressure, tick is a strobe.
module seg7_scan_mux
   import seg7_scan_mux_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter bit SEG_AL  = 1'b1,
   parameter bit AN_AL   = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   seg7_scan_mux_if.slave bus
);

   localparam int              IW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int              DW      = 4 * NDIGITS;
   localparam logic [IW-1:0]   LAST    = IW'(NDIGITS - 1);
   localparam logic [NDIGITS-1:0] AN_OFF = {NDIGITS{AN_AL}};
   localparam logic [6:0]      SEG_OFF = {7{SEG_AL}};
   localparam logic            DP_OFF  = SEG_AL;

   logic [0:0]          state, state_nxt;
   logic [IW-1:0]       idx, idx_nxt;
   logic                pending, pending_nxt;
   logic [DW-1:0]       staging_dig;
   logic [NDIGITS-1:0]  staging_dp;
   logic [DW-1:0]       shadow_dig, shadow_dig_nxt;
   logic [NDIGITS-1:0]  shadow_dp, shadow_dp_nxt;
   logic                boundary;

   logic [NDIGITS-1:0]  an_q;
   logic [6:0]          seg_q;
   logic                dp_q;
   logic                frame_done_q;

   logic [NDIGITS-1:0]  onehot;
   logic [NDIGITS-1:0]  lz_blank;
   logic                upper_zero;
   logic [3:0]          sel_nib;
   logic                sel_dp;
   logic                sel_blank;
   logic [6:0]          dec_segs;

   // Frame boundary: the tick that ends SHOW of the last digit.
   assign boundary = bus.tick && (state == ST_SHOW) && (idx == LAST);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (bus.tick) begin
         if (state == ST_BLANK) begin
            state_nxt = ST_SHOW;
         end else begin
            state_nxt = ST_BLANK;
            idx_nxt   = (idx == LAST) ? '0 : idx + 1'b1;
         end
      end
   end

   // A load landing on the boundary edge bypasses staging and goes straight to display.
   always_comb begin
      shadow_dig_nxt = shadow_dig;
      shadow_dp_nxt  = shadow_dp;
      pending_nxt    = pending;
      if (boundary) begin
         pending_nxt = 1'b0;
         if (bus.load) begin
            shadow_dig_nxt = bus.digits;
            shadow_dp_nxt  = bus.dp_in;
         end else if (pending) begin
            shadow_dig_nxt = staging_dig;
            shadow_dp_nxt  = staging_dp;
         end
      end else if (bus.load) begin
         pending_nxt = 1'b1;
      end
   end

   // Digit i>0 is a leading zero when it and every digit above it are zero.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int i = NDIGITS - 1; i > 0; i--) begin
         upper_zero  = upper_zero && (shadow_dig_nxt[4*i +: 4] == 4'h0);
         lz_blank[i] = upper_zero;
      end
   end

   always_comb begin
      onehot    = '0;
      sel_nib   = 4'h0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_nxt == IW'(i)) begin
            onehot[i] = 1'b1;
            sel_nib   = shadow_dig_nxt[4*i +: 4];
            sel_dp    = shadow_dp_nxt[i];
            sel_blank = bus.lz_en && lz_blank[i];
         end
      end
   end

   seg7_hex_decode u_decode (
      .nibble (sel_nib),
      .segs   (dec_segs)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_BLANK;
         idx          <= '0;
         pending      <= 1'b0;
         staging_dig  <= '0;
         staging_dp   <= '0;
         shadow_dig   <= '0;
         shadow_dp    <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         pending      <= pending_nxt;
         shadow_dig   <= shadow_dig_nxt;
         shadow_dp    <= shadow_dp_nxt;
         frame_done_q <= boundary;
         if (bus.load) begin
            staging_dig <= bus.digits;
            staging_dp  <= bus.dp_in;
         end
         if (state_nxt == ST_SHOW) begin
            an_q  <= AN_AL ? ~onehot : onehot;
            seg_q <= sel_blank ? SEG_OFF : seg_pol(dec_segs, SEG_AL);
            dp_q  <= sel_dp ^ SEG_AL;
         end else begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule
